uart_fifo: RTL and testbench
============================

// Module: uart_fifo
// PURPOSE
//  Buffered 8N1 RS-232 UART, memory-mapped peripheral on the data bus. Successor to the single-byte UART:
//  parametrised clock/baud, TX and RX FIFOs, 16x oversampled receiver with mid-bit sampling,
//  framing/overrun detection and maskable interrupt. Instruction port reads 0 (no execution from UART).
// PARAMETERS
//  CLK_HZ      25000000  system clock frequency
//  BAUD        57600     line rate; DIV = CLK_HZ/(16*BAUD), must be >= 1
//  FIFO_DEPTH  16        entries per FIFO, power of two, >= 2
// PORTS
//  clk    in   1   system clock, all state on rising edge
//  rst    in   1   reset, synchronous, active-high
//  de     in   1   data bus enable
//  drw    in   2   [1]=read strobe, [0]=write strobe
//  daddr  in   32  byte address, decoded on bits [4:2], upper bits ignored
//  din    in   32  write data
//  dout   out  32  read data, combinational from daddr
//  iout   out  32  constant 0
//  rxd    in   1   serial input, asynchronous
//  txd    out  1   serial output
//  irq    out  1   interrupt request, registered
// BEHAVIOUR
//  Register map: 0x00 CMD (reads 0); 0x04 STATUS; 0x08 RXDATA; 0x0C TXDATA; 0x10 CTRL.
//  CMD write: bit0 clear OVR/FERR, bit1 flush RX FIFO, bit2 flush TX FIFO; bits act in the same cycle.
//  STATUS = {16'b0, rx_count[7:0], 2'b0, FERR, OVR, rx_full, tx_full, rx_avail, tx_idle}; rx_count saturates at 255.
//   tx_idle = TX FIFO empty AND shifter idle; rx_avail = RX FIFO non-empty.
//  RXDATA read (de & drw[1] & addr 0x08): dout={24'b0,head}; pop on that edge. Empty: dout=0, no pop.
//  TXDATA write: push din[7:0]; write when full is dropped silently, FIFO unchanged. Read returns 0.
//  CTRL: bit0 rx_ie, bit1 tx_ie, rest reads 0. irq next cycle = (rx_ie&rx_avail)|(tx_ie&tx_idle)|(rx_ie&(OVR|FERR)).
//  Reset: FIFOs empty, CTRL=0, OVR=FERR=0, txd=1, irq=0, both FSMs IDLE, tick counter 0.
//  Tick: counter 0..DIV-1, 1-cycle tick when it wraps; free-running, cleared only by rst.
//  RX: rxd through 2-flop synchroniser. States IDLE->START->DATA(8)->STOP->IDLE, ticks counted 0..15 per bit.
//   IDLE: low sample on a tick -> START, count=0. START: at count 7 if line high -> IDLE (glitch), else bit timing
//   realigned so every later sample is 16 ticks apart (mid-bit). DATA: LSB first. STOP at mid-bit:
//   high & FIFO not full -> push; high & full -> byte dropped, OVR=1; low -> byte dropped, FERR=1, return to IDLE
//   only after line seen high (no false start on break).
//  TX: IDLE with FIFO non-empty -> pop into shifter, START(txd=0,16 ticks) -> DATA 8 bits LSB first -> STOP(txd=1,
//   16 ticks) -> IDLE; back-to-back frames with no gap. First bit edge aligns to next tick (<=DIV cycles latency).
//  FIFO: simultaneous push and pop allowed in all states, count unchanged; full push with pop succeeds.
//  Simultaneous: flush RX + internal push same cycle -> FIFO empty (flush wins). Flush TX mid-frame: current
//   frame completes, queued bytes discarded. Clear OVR + new overrun same cycle -> OVR stays 1.
//  rst mid-frame: txd returns to 1 next cycle, partial RX byte discarded.
// TESTING  (CLK_HZ=3200000, BAUD=100000 -> DIV=2, 32 clk/bit)
//  Write 0x55 to 0x0C -> txd: 0,1,0,1,0,1,0,1,0,1 each 32 clk; tx_idle=0 during frame, 1 after stop.
//  Write 0xA1,0x02,0x7F back-to-back -> three contiguous frames, 960 clk total, no idle gap.
//  Drive rxd frame 0x3C -> STATUS bit1=1, rx_count=1; read 0x08 -> 0x3C, next STATUS bit1=0.
//  Send FIFO_DEPTH+1 RX frames, no reads -> rx_full=1, OVR=1, first 16 bytes intact; CMD 0x1 -> OVR=0.
//  RX frame with stop bit 0 -> FERR=1, no push; 2-tick low glitch on idle rxd -> no frame, no flags.
//  CTRL=0x1, receive byte -> irq=1 one cycle after push; read RXDATA -> irq=0; rst mid-TX -> txd=1, irq=0.

Source files
------------

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo (with helper uart_fifo_buf)
//  Purpose  : Buffered 8N1 UART peripheral on the data bus: TX/RX byte
//             FIFOs, 16x oversampled receiver, framing/overrun flags and a
//             maskable registered interrupt.
//  Revision : 1.0 - initial release
// ============================================================================

module uart_fifo_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o,
    output logic [AW:0]   count_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_CNT);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rptr_q];
    // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
    assign w_pop_ok  = pop_i & ~empty_o;
    assign w_push_ok = push_i & (~full_o | w_pop_ok);

    // Storage array, no reset needed: contents are only visible through count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; flush has priority over any push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push_ok) wptr_q <= wptr_q + AW'(1);
            if (w_pop_ok)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        end
    end
endmodule

module uart_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 57600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic [1:0]  drw,
    input  logic [31:0] daddr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [31:0] iout,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);
    localparam int DIV = CLK_HZ / (16 * BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);

    localparam logic [2:0] A_CMD  = 3'd0;
    localparam logic [2:0] A_STAT = 3'd1;
    localparam logic [2:0] A_RXD  = 3'd2;
    localparam logic [2:0] A_TXD  = 3'd3;
    localparam logic [2:0] A_CTRL = 3'd4;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // ---------------- bus decode ----------------
    logic [2:0] w_addr;
    logic       w_rd, w_wr, w_cmd_wr, w_clr_err, w_flush_rx, w_flush_tx;
    logic       w_rx_pop, w_tx_push;

    assign w_addr     = daddr[4:2];
    assign w_rd       = de & drw[1];
    assign w_wr       = de & drw[0];
    assign w_cmd_wr   = w_wr & (w_addr == A_CMD);
    assign w_clr_err  = w_cmd_wr & din[0];
    assign w_flush_rx = w_cmd_wr & din[1];
    assign w_flush_tx = w_cmd_wr & din[2];
    assign w_tx_push  = w_wr & (w_addr == A_TXD);
    assign iout       = 32'd0;

    // ---------------- baud tick ----------------
    logic [DW-1:0] tick_cnt_q;
    logic          w_tick;
    assign w_tick = (tick_cnt_q == DIV_M1);

    // Free-running 16x oversampling tick generator.
    always_ff @(posedge clk) begin
        if (rst) tick_cnt_q <= '0;
        else     tick_cnt_q <= w_tick ? '0 : tick_cnt_q + DW'(1);
    end

    // ---------------- FIFOs ----------------
    logic [7:0]  w_rx_head, w_tx_head, w_rx_sh_out;
    logic [AW:0] w_rx_count, w_tx_count;
    logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic        w_rx_push_req, w_tx_pop;

    assign w_rx_pop = w_rd & (w_addr == A_RXD) & ~w_rx_empty;

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_rx_fifo (
        .clk(clk), .rst(rst), .flush_i(w_flush_rx), .push_i(w_rx_push_req),
        .pop_i(w_rx_pop), .wdata_i(w_rx_sh_out), .rdata_o(w_rx_head),
        .count_o(w_rx_count), .empty_o(w_rx_empty), .full_o(w_rx_full)
    );

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_tx_fifo (
        .clk(clk), .rst(rst), .flush_i(w_flush_tx), .push_i(w_tx_push),
        .pop_i(w_tx_pop), .wdata_i(din[7:0]), .rdata_o(w_tx_head),
        .count_o(w_tx_count), .empty_o(w_tx_empty), .full_o(w_tx_full)
    );

    // ---------------- receiver ----------------
    logic      rxd_s1_q, rxd_s2_q;
    rx_state_t rx_state_q, rx_state_d;
    logic [3:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic       w_ferr_set, w_ovr_set;

    assign w_rx_sh_out = rx_sh_q;
    // Overrun only when the stop bit is good but no slot is (or becomes) free.
    assign w_ovr_set   = w_rx_push_req & w_rx_full & ~w_rx_pop;

    // Two-flop synchroniser for the asynchronous serial input (idles high).
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
        end else begin
            rxd_s1_q <= rxd;
            rxd_s2_q <= rxd_s1_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    // Receiver next state: start qualified at half-bit, then one sample per 16 ticks.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_sh_d       = rx_sh_q;
        w_rx_push_req = 1'b0;
        w_ferr_set    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (w_tick && !rxd_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = 4'd0;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if (rx_cnt_q == 4'd7) begin
                        rx_cnt_d = 4'd0;
                        rx_bit_d = 3'd0;
                        rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    if (rx_cnt_q == 4'd15) begin
                        rx_cnt_d = 4'd0;
                        rx_sh_d  = {rxd_s2_q, rx_sh_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                        else                  rx_bit_d   = rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    if (rx_cnt_q == 4'd15) begin
                        rx_cnt_d = 4'd0;
                        if (rxd_s2_q) begin
                            w_rx_push_req = 1'b1;
                            rx_state_d    = RX_IDLE;
                        end else begin
                            w_ferr_set = 1'b1;
                            rx_state_d = RX_BRK;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
            end
            RX_BRK: begin
                // Hold off until the line recovers so a break is not read as a start bit.
                if (rxd_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- transmitter ----------------
    tx_state_t tx_state_q, tx_state_d;
    logic [3:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       txd_q, txd_d;
    logic       w_tx_idle;

    assign txd       = txd_q;
    assign w_tx_idle = w_tx_empty & (tx_state_q == TX_IDLE);

    // Transmitter state register; line idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'd0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
        end
    end

    // Transmitter next state: every bit lasts 16 ticks; stop chains straight into the next start.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        txd_d      = txd_q;
        w_tx_pop   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (w_tick && !w_tx_empty) begin
                    w_tx_pop   = 1'b1;
                    tx_sh_d    = w_tx_head;
                    txd_d      = 1'b0;
                    tx_cnt_d   = 4'd0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (w_tick) begin
                    if (tx_cnt_q == 4'd15) begin
                        tx_cnt_d   = 4'd0;
                        tx_bit_d   = 3'd0;
                        txd_d      = tx_sh_q[0];
                        tx_state_d = TX_DATA;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
            TX_DATA: begin
                if (w_tick) begin
                    if (tx_cnt_q == 4'd15) begin
                        tx_cnt_d = 4'd0;
                        if (tx_bit_q == 3'd7) begin
                            txd_d      = 1'b1;
                            tx_state_d = TX_STOP;
                        end else begin
                            tx_bit_d = tx_bit_q + 3'd1;
                            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                            txd_d    = tx_sh_q[1];
                        end
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
            TX_STOP: begin
                if (w_tick) begin
                    if (tx_cnt_q == 4'd15) begin
                        tx_cnt_d = 4'd0;
                        if (!w_tx_empty) begin
                            w_tx_pop   = 1'b1;
                            tx_sh_d    = w_tx_head;
                            txd_d      = 1'b0;
                            tx_state_d = TX_START;
                        end else begin
                            txd_d      = 1'b1;
                            tx_state_d = TX_IDLE;
                        end
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------- flags, control, interrupt ----------------
    logic ovr_q, ferr_q, rx_ie_q, tx_ie_q, irq_q;
    assign irq = irq_q;

    // Sticky error flags: a new event in the clearing cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= w_ovr_set  | (ovr_q  & ~w_clr_err);
            ferr_q <= w_ferr_set | (ferr_q & ~w_clr_err);
        end
    end

    // Interrupt enables and the registered interrupt line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ie_q <= 1'b0;
            tx_ie_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (w_wr && (w_addr == A_CTRL)) begin
                rx_ie_q <= din[0];
                tx_ie_q <= din[1];
            end
            irq_q <= (rx_ie_q & ~w_rx_empty) | (tx_ie_q & w_tx_idle) | (rx_ie_q & (ovr_q | ferr_q));
        end
    end

    // ---------------- read mux ----------------
    logic [31:0] w_rx_cnt32;
    logic [7:0]  w_rx_cnt8;
    logic [31:0] w_status;

    assign w_rx_cnt32 = 32'(w_rx_count);
    assign w_rx_cnt8  = (w_rx_cnt32 > 32'd255) ? 8'hFF : w_rx_cnt32[7:0];
    assign w_status   = {16'd0, w_rx_cnt8, 2'b00, ferr_q, ovr_q, w_rx_full, w_tx_full,
                         ~w_rx_empty, w_tx_idle};

    // Combinational read data selected by address alone.
    always_comb begin
        dout = 32'd0;
        case (w_addr)
            A_STAT: dout = w_status;
            A_RXD:  dout = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
            A_CTRL: dout = {30'd0, tx_ie_q, rx_ie_q};
            default: dout = 32'd0;
        endcase
    end

    logic w_unused;
    assign w_unused = &{1'b0, daddr[31:5], daddr[1:0], din[31:8], w_tx_count};
endmodule

`default_nettype wire

// File: tb/tb_uart_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_fifo
//  Purpose  : Directed self-checking bench for uart_fifo at DIV=2
//             (32 clocks per bit, 320 clocks per frame).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo;
    logic        clk = 1'b0;
    logic        rst, de, rxd;
    logic [1:0]  drw;
    logic [31:0] daddr, din;
    logic [31:0] dout, iout;
    logic        txd, irq;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    uart_fifo #(.CLK_HZ(3200000), .BAUD(100000), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .de(de), .drw(drw), .daddr(daddr), .din(din),
        .dout(dout), .iout(iout), .rxd(rxd), .txd(txd), .irq(irq)
    );

    // All helpers are entered and left on a falling clock edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        de = 1'b1; drw = 2'b01; daddr = a; din = d;
        @(negedge clk);
        de = 1'b0; drw = 2'b00;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        de = 1'b1; drw = 2'b10; daddr = a;
        #1 d = dout;
        @(negedge clk);
        de = 1'b0; drw = 2'b00;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        daddr = a;
        #1 d = dout;
    endtask

    task automatic do_reset;
        rst = 1'b1; de = 1'b0; drw = 2'b00; daddr = 32'd0; din = 32'd0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv);
        rxd = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (32) @(negedge clk);
        end
        rxd = stopv;
        repeat (32) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_txd_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [7:0] ovr_byte(input int i);
        return 8'(i * 17 + 5);
    endfunction

    task automatic test_reset;
        logic [31:0] v;
        do_reset();
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0001) begin nerr++; $display("FAIL reset_status got %h exp %h", v, 32'h1); end
        nvec++; if (txd !== 1'b1) begin nerr++; $display("FAIL reset_txd got %b exp 1", txd); end
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL reset_irq got %b exp 0", irq); end
        nvec++; if (iout !== 32'd0) begin nerr++; $display("FAIL iout got %h exp 0", iout); end
        bus_read(32'h10, v);
        nvec++; if (v !== 32'd0) begin nerr++; $display("FAIL reset_ctrl got %h exp 0", v); end
        bus_read(32'h08, v);
        nvec++; if (v !== 32'd0) begin nerr++; $display("FAIL reset_rxdata got %h exp 0", v); end
        bus_read(32'h00, v);
        nvec++; if (v !== 32'd0) begin nerr++; $display("FAIL cmd_read got %h exp 0", v); end
    endtask

    task automatic test_tx_single;
        logic [31:0] v;
        logic [9:0]  fr;
        bit ok;
        fr = {1'b1, 8'h55, 1'b0};
        bus_write(32'h0C, 32'h55);
        wait_txd_low(ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL tx1_start got no start bit exp start within 20 clk"); end
        repeat (16) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (32) @(negedge clk);
            nvec++; if (txd !== fr[k]) begin nerr++; $display("FAIL tx1_bit%0d got %b exp %b", k, txd, fr[k]); end
            if (k == 4) begin
                peek(32'h04, v);
                nvec++; if (v[0] !== 1'b0) begin nerr++; $display("FAIL tx1_busy got tx_idle=%b exp 0", v[0]); end
            end
        end
        repeat (20) @(negedge clk);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0001) begin nerr++; $display("FAIL tx1_done_status got %h exp %h", v, 32'h1); end
        nvec++; if (txd !== 1'b1) begin nerr++; $display("FAIL tx1_line_idle got %b exp 1", txd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        logic [29:0] st;
        bit ok;
        st = {1'b1, 8'h7F, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'hA1, 1'b0};
        bus_write(32'h0C, 32'hA1);
        bus_write(32'h0C, 32'h02);
        bus_write(32'h0C, 32'h7F);
        wait_txd_low(ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL b2b_start got no start bit exp start within 20 clk"); end
        repeat (16) @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            if (k > 0) repeat (32) @(negedge clk);
            nvec++; if (txd !== st[k]) begin nerr++; $display("FAIL b2b_bit%0d got %b exp %b", k, txd, st[k]); end
        end
        repeat (10) @(negedge clk);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0000) begin nerr++; $display("FAIL b2b_in_stop got %h exp %h", v, 32'h0); end
        repeat (10) @(negedge clk);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0001) begin nerr++; $display("FAIL b2b_done got %h exp %h", v, 32'h1); end
    endtask

    task automatic test_rx_single;
        logic [31:0] v;
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0103) begin nerr++; $display("FAIL rx1_status got %h exp %h", v, 32'h103); end
        bus_read(32'h08, v);
        nvec++; if (v !== 32'h0000_003C) begin nerr++; $display("FAIL rx1_data got %h exp %h", v, 32'h3C); end
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0001) begin nerr++; $display("FAIL rx1_after_read got %h exp %h", v, 32'h1); end
    endtask

    task automatic test_overrun;
        logic [31:0] v;
        do_reset();
        for (int i = 0; i < 17; i++) send_frame(ovr_byte(i), 1'b1);
        repeat (4) @(negedge clk);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_101B) begin nerr++; $display("FAIL ovr_status got %h exp %h", v, 32'h101B); end
        bus_write(32'h00, 32'h1);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_100B) begin nerr++; $display("FAIL ovr_clear got %h exp %h", v, 32'h100B); end
        for (int i = 0; i < 16; i++) begin
            bus_read(32'h08, v);
            nvec++; if (v !== {24'd0, ovr_byte(i)}) begin nerr++; $display("FAIL ovr_data%0d got %h exp %h", i, v, ovr_byte(i)); end
        end
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0001) begin nerr++; $display("FAIL ovr_drained got %h exp %h", v, 32'h1); end
        bus_read(32'h08, v);
        nvec++; if (v !== 32'd0) begin nerr++; $display("FAIL rx_empty_read got %h exp 0", v); end
    endtask

    task automatic test_ferr_glitch;
        logic [31:0] v;
        do_reset();
        send_frame(8'hA5, 1'b0);
        repeat (40) @(negedge clk);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0021) begin nerr++; $display("FAIL ferr_status got %h exp %h", v, 32'h21); end
        bus_write(32'h00, 32'h1);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0001) begin nerr++; $display("FAIL ferr_clear got %h exp %h", v, 32'h1); end
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (400) @(negedge clk);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0001) begin nerr++; $display("FAIL glitch_status got %h exp %h", v, 32'h1); end
    endtask

    task automatic test_flush;
        logic [31:0] v;
        bit ok;
        do_reset();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0203) begin nerr++; $display("FAIL rxflush_pre got %h exp %h", v, 32'h203); end
        bus_write(32'h00, 32'h2);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0001) begin nerr++; $display("FAIL rxflush_post got %h exp %h", v, 32'h1); end
        bus_write(32'h0C, 32'hF0);
        bus_write(32'h0C, 32'h0F);
        bus_write(32'h0C, 32'hAA);
        wait_txd_low(ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL txflush_start got no start bit exp start within 20 clk"); end
        bus_write(32'h00, 32'h4);
        repeat (8) @(negedge clk);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0000) begin nerr++; $display("FAIL txflush_mid got %h exp %h", v, 32'h0); end
        repeat (320) @(negedge clk);
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0001) begin nerr++; $display("FAIL txflush_end got %h exp %h", v, 32'h1); end
        nvec++; if (txd !== 1'b1) begin nerr++; $display("FAIL txflush_line got %b exp 1", txd); end
    endtask

    task automatic test_irq;
        logic [31:0] v;
        int avail_c, irq_c;
        do_reset();
        bus_write(32'h10, 32'h1);
        bus_read(32'h10, v);
        nvec++; if (v !== 32'h1) begin nerr++; $display("FAIL ctrl_read got %h exp %h", v, 32'h1); end
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_quiet got %b exp 0", irq); end
        avail_c = -1; irq_c = -1;
        daddr = 32'h04;
        fork
            send_frame(8'h42, 1'b1);
            for (int c = 0; c < 360; c++) begin
                @(negedge clk);
                if (avail_c < 0 && dout[1] === 1'b1) avail_c = c;
                if (irq_c < 0 && irq === 1'b1) irq_c = c;
            end
        join
        nvec++; if (avail_c < 0 || irq_c != avail_c + 1) begin nerr++; $display("FAIL irq_latency got irq@%0d exp avail@%0d+1", irq_c, avail_c); end
        bus_read(32'h08, v);
        nvec++; if (v !== 32'h42) begin nerr++; $display("FAIL irq_data got %h exp %h", v, 32'h42); end
        repeat (2) @(negedge clk);
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_after_read got %b exp 0", irq); end
        bus_write(32'h10, 32'h2);
        repeat (2) @(negedge clk);
        nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL irq_txidle got %b exp 1", irq); end
    endtask

    task automatic test_rst_mid_tx;
        logic [31:0] v;
        bit ok;
        bus_write(32'h10, 32'h3);
        bus_write(32'h0C, 32'h00);
        wait_txd_low(ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL rsttx_start got no start bit exp start within 20 clk"); end
        repeat (40) @(negedge clk);
        nvec++; if (txd !== 1'b0) begin nerr++; $display("FAIL rsttx_mid got %b exp 0", txd); end
        rst = 1'b1;
        @(negedge clk);
        nvec++; if (txd !== 1'b1) begin nerr++; $display("FAIL rsttx_txd got %b exp 1", txd); end
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL rsttx_irq got %b exp 0", irq); end
        rst = 1'b0;
        peek(32'h04, v);
        nvec++; if (v !== 32'h0000_0001) begin nerr++; $display("FAIL rsttx_status got %h exp %h", v, 32'h1); end
        bus_read(32'h10, v);
        nvec++; if (v !== 32'd0) begin nerr++; $display("FAIL rsttx_ctrl got %h exp 0", v); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_single();
        test_overrun();
        test_ferr_glitch();
        test_flush();
        test_irq();
        test_rst_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
